alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter: ZERO_SKIP, 1, when 1 a zero operand completes without iterating.
REQ-002 Parameter: ITER, 32, number of shift-add iterations (fixed by the 32-bit datapath).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_a  input  32  multiplicand, unsigned.
REQ-008 req_b  input  32  multiplier, unsigned.
REQ-009 req_hi  input  1  0 selects low 32 product bits (MUL); 1 selects high 32 bits (MULHU).
REQ-010 flush  input  1  abandon the operation in flight.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  consumer accepts the result.
REQ-013 resp_data  output  32  selected product half.
REQ-014 alu_A  output  32  ALU operand A.
REQ-015 alu_B  output  32  ALU operand B.
REQ-016 alu_ALUop  output  12  one-hot ALU op; bit0 = add.
REQ-017 alu_Result  input  32  ALU result, combinational from alu_A/alu_B/alu_ALUop.
REQ-018 alu_CarryOut  input  1  ALU carry out of the add.

Function
REQ-019 States SHALL be IDLE, RUN, DONE; transitions occur only on rising clk edges.
REQ-020 req_ready SHALL be 1 exactly in IDLE; a request is accepted when req_valid & req_ready.
REQ-021 On accept, the block SHALL latch mcand=req_a, hi=0, lo=req_b, sel=req_hi, cnt=0 and enter RUN.
REQ-022 With ZERO_SKIP=1 and req_a==0 or req_b==0 at accept, the block SHALL latch a zero product and enter DONE directly (resp_valid on the next cycle).
REQ-023 In RUN, alu_ALUop SHALL be 12'h001, alu_A = hi, alu_B = lo[0] ? mcand : 0.
REQ-024 Each RUN cycle SHALL update {hi, lo} <= {alu_CarryOut, alu_Result, lo[31:1]} and increment cnt.
REQ-025 RUN SHALL last exactly ITER cycles; after the cycle with cnt==ITER-1 the block enters DONE.
REQ-026 Outside RUN, alu_ALUop, alu_A and alu_B SHALL be 0.
REQ-027 Latency: request accepted at edge T, resp_valid SHALL be 1 in the cycle following edge T+32.
REQ-028 In DONE, resp_valid SHALL be 1 and resp_data SHALL be sel ? hi : lo, held stable until resp_ready.
REQ-029 DONE with resp_ready=1 SHALL return to IDLE; a new request is accepted no earlier than the next cycle.
REQ-030 resp_valid SHALL be 0 in IDLE and RUN; resp_data SHALL be 0 whenever resp_valid is 0.
REQ-031 flush=1 SHALL force IDLE on the next edge from any state, discarding any result, and takes priority over accept and response handshakes.
REQ-032 Products SHALL be exact 64-bit unsigned results; no overflow indication is produced.

Reset
REQ-033 rst=1 SHALL, on the next edge, force IDLE, cnt=0, hi=lo=mcand=0, sel=0; rst overrides flush and all handshakes.
REQ-034 While in reset and the cycle after reset, the outputs SHALL be req_ready=1 (IDLE), resp_valid=0, resp_data=0 and alu_* = 0.
REQ-035 rst asserted mid-RUN SHALL abandon the operation with no response emitted.

Verification
REQ-036 a=3, b=5, hi=0 -> resp_data=0x0000000F, resp_valid rises 33 cycles after accept.
REQ-037 a=b=0xFFFFFFFF: hi=1 -> 0xFFFFFFFE; hi=0 -> 0x00000001; alu_ALUop=0x001 on all 32 RUN cycles.
REQ-038 ZERO_SKIP=1, a=0, b=0x1234 -> resp_data=0, resp_valid in the cycle after accept, alu_ALUop stays 0.
REQ-039 a=0x10000, b=0x10000, hi=1, resp_ready low 5 cycles -> resp_data=0x00000001 held stable, req_ready=0 until release.
REQ-040 flush at RUN cycle 10, then a new request a=7, b=6 -> no response for the first request; resp_data=42 after 33 cycles.
REQ-041 rst at RUN cycle 20 -> next cycle req_ready=1, resp_valid=0; the subsequent a=2, b=2 multiply yields 4.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier driving an external ALU.
// Returns either the low (MUL) or high (MULHU) half of the 64-bit product.
module alu_mul_seq #(
    parameter int ZERO_SKIP = 1,
    parameter int ITER      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_hi,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [11:0] alu_ALUop,
    input  logic [31:0] alu_Result,
    input  logic        alu_CarryOut
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   mcand, hi, lo;
    logic          sel;
    logic [CW-1:0] cnt;
    logic          accept, zero_op, last_iter;

    assign accept    = (state == IDLE) && req_valid && !flush;
    assign zero_op   = (ZERO_SKIP != 0) && ((req_a == 32'd0) || (req_b == 32'd0));
    assign last_iter = (cnt == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (req_valid) state_nx = zero_op ? DONE : RUN;
                RUN:     if (last_iter) state_nx = DONE;
                DONE:    if (resp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // {hi,lo} shifts right each step; the ALU sum plus carry lands in the top 33 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            sel   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            sel <= req_hi;
            cnt <= '0;
            hi  <= '0;
            if (zero_op) begin
                mcand <= '0;
                lo    <= '0;
            end else begin
                mcand <= req_a;
                lo    <= req_b;
            end
        end else if (state == RUN && !flush) begin
            hi  <= {alu_CarryOut, alu_Result[31:1]};
            lo  <= {alu_Result[0], lo[31:1]};
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
        resp_data  = resp_valid ? (sel ? hi : lo) : 32'd0;
        alu_ALUop  = 12'h000;
        alu_A      = 32'd0;
        alu_B      = 32'd0;
        if (state == RUN) begin
            alu_ALUop = 12'h001;
            alu_A     = hi;
            alu_B     = lo[0] ? mcand : 32'd0;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq; the bench supplies the adder the block drives.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_hi, flush, resp_ready;
    logic [31:0] req_a, req_b;
    logic        req_ready, resp_valid;
    logic [31:0] resp_data, alu_A, alu_B, alu_Result;
    logic [11:0] alu_ALUop;
    logic        alu_CarryOut;
    logic [32:0] sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sum          = alu_ALUop[0] ? ({1'b0, alu_A} + {1'b0, alu_B}) : 33'd0;
    assign alu_Result   = sum[31:0];
    assign alu_CarryOut = sum[32];

    alu_mul_seq #(.ZERO_SKIP(1), .ITER(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_hi(req_hi), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
        .alu_Result(alu_Result), .alu_CarryOut(alu_CarryOut)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        hi;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic h);
        @(negedge clk);
        chk("req_ready before accept", {31'd0, req_ready}, 32'd1);
        req_a = a; req_b = b; req_hi = h; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until resp_valid, and RUN-op cycles seen.
    task automatic wait_resp(output int lat, output int nadd);
        lat = 0; nadd = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (alu_ALUop == 12'h001) nadd++;
            if (resp_valid) break;
            if (req_ready) begin
                chk("response lost", 32'd0, 32'd1);
                break;
            end
            if (lat > 100) begin
                chk("response timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic finish_resp(input string name, input int hold, input logic [31:0] exp);
        chk({name, " data"}, resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " held data"}, resp_data, exp);
            chk({name, " held req_ready"}, {31'd0, req_ready}, 32'd0);
            chk({name, " held valid"}, {31'd0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({name, " idle after"}, {30'd0, resp_valid, req_ready}, 32'd1);
        chk({name, " data cleared"}, resp_data, 32'd0);
    endtask

    vec_t vecs[12];
    int   lat, nadd;

    initial begin
        vecs[0]  = '{32'd3,          32'd5,          1'b0, 32'h0000000F};
        vecs[1]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFE};
        vecs[2]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h00000001};
        vecs[3]  = '{32'h00010000,   32'h00010000,   1'b1, 32'h00000001};
        vecs[4]  = '{32'h00010000,   32'h00010000,   1'b0, 32'h00000000};
        vecs[5]  = '{32'h12345678,   32'h00000010,   1'b0, 32'h23456780};
        vecs[6]  = '{32'h12345678,   32'h00000010,   1'b1, 32'h00000001};
        vecs[7]  = '{32'd7,          32'd6,          1'b0, 32'd42};
        vecs[8]  = '{32'd0,          32'h00001234,   1'b0, 32'd0};
        vecs[9]  = '{32'h00001234,   32'd0,          1'b1, 32'd0};
        vecs[10] = '{32'h80000000,   32'd2,          1'b1, 32'd1};
        vecs[11] = '{32'h80000000,   32'd2,          1'b0, 32'd0};

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_hi = 1'b0;
        flush = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_data", resp_data, 32'd0);
        chk("reset alu_ALUop", {20'd0, alu_ALUop}, 32'd0);
        chk("reset alu_A|B", alu_A | alu_B, 32'd0);
        #1 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            logic zero;
            zero = (vecs[i].a == 0) || (vecs[i].b == 0);
            start_req(vecs[i].a, vecs[i].b, vecs[i].hi);
            wait_resp(lat, nadd);
            chk($sformatf("vec%0d latency", i), lat, zero ? 32'd1 : 32'd33);
            chk($sformatf("vec%0d add cycles", i), nadd, zero ? 32'd0 : 32'd32);
            finish_resp($sformatf("vec%0d", i), 0, vecs[i].exp);
        end

        // Back-pressure: result held while resp_ready stays low.
        start_req(32'h00010000, 32'h00010000, 1'b1);
        wait_resp(lat, nadd);
        finish_resp("backpressure", 5, 32'h00000001);

        // Flush mid-RUN discards the first product.
        start_req(32'd3, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre-flush in RUN", {20'd0, alu_ALUop}, 32'h001);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("post-flush idle", {30'd0, resp_valid, req_ready}, 32'd1);
        chk("post-flush alu_ALUop", {20'd0, alu_ALUop}, 32'd0);
        start_req(32'd7, 32'd6, 1'b0);
        wait_resp(lat, nadd);
        chk("after-flush latency", lat, 32'd33);
        finish_resp("after-flush", 0, 32'd42);

        // Flush beats a simultaneous request.
        @(negedge clk);
        req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush blocks accept", {30'd0, resp_valid, req_ready}, 32'd1);
        chk("flush blocks ALU", {20'd0, alu_ALUop}, 32'd0);

        // Reset mid-RUN abandons the operation.
        start_req(32'hFFFF, 32'hFFFF, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-run reset idle", {30'd0, resp_valid, req_ready}, 32'd1);
        chk("mid-run reset alu", {20'd0, alu_ALUop} | alu_A | alu_B, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after reset no resp", {31'd0, resp_valid}, 32'd0);
        start_req(32'd2, 32'd2, 1'b0);
        wait_resp(lat, nadd);
        chk("after-reset latency", lat, 32'd33);
        finish_resp("after-reset", 0, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end
endmodule
